// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, issue-stall generation,
// optional writeback-to-read bypass and a sticky writeback protocol error.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_da,
    input  logic                iss_pair,
    input  logic [ADDR_W-1:0]   iss_aa,
    input  logic [ADDR_W-1:0]   iss_ba,
    input  logic                iss_use_a,
    input  logic                iss_use_b,
    output logic                stall,
    output logic [DATA_W-1:0]   a_data,
    output logic [DATA_W-1:0]   b_data,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_da,
    input  logic                wb_pair,
    input  logic [2*DATA_W-1:0] wb_data,
    output logic                idle,
    output logic                wb_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_idle;
    logic              r_err;

    logic [ADDR_W-1:0] w_iss_da1;
    logic [ADDR_W-1:0] w_wb_da1;
    logic [DATA_W-1:0] w_wb_lo;
    logic [DATA_W-1:0] w_wb_hi;
    logic [DEPTH-1:0]  w_wr_mask;
    logic [DEPTH-1:0]  w_eff_busy;
    logic [DEPTH-1:0]  w_iss_mask;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_err_set;

    // Pair partners wrap modulo depth through natural ADDR_W overflow
    assign w_iss_da1 = iss_da + ADDR_W'(1);
    assign w_wb_da1  = wb_da + ADDR_W'(1);
    assign w_wb_lo   = wb_data[DATA_W-1:0];
    assign w_wb_hi   = wb_data[2*DATA_W-1:DATA_W];

    // One-hot set of registers written this cycle; R0 is never a target
    always_comb begin
        w_wr_mask = '0;
        if (wb_en) begin
            w_wr_mask[wb_da] = 1'b1;
            if (wb_pair) begin
                w_wr_mask[w_wb_da1] = 1'b1;
            end
        end
        w_wr_mask[0] = 1'b0;
    end

    // With bypass, a register being written back now no longer blocks issue
    assign w_eff_busy = BYPASS ? (r_busy & ~w_wr_mask) : r_busy;

    assign stall = iss_valid & ((iss_use_a & w_eff_busy[iss_aa]) |
                                (iss_use_b & w_eff_busy[iss_ba]) |
                                w_eff_busy[iss_da] |
                                (iss_pair & w_eff_busy[w_iss_da1]));

    // Busy bits claimed by an accepted issue; R0 is never claimed
    always_comb begin
        w_iss_mask = '0;
        if (iss_valid && !stall) begin
            w_iss_mask[iss_da] = 1'b1;
            if (iss_pair) begin
                w_iss_mask[w_iss_da1] = 1'b1;
            end
        end
        w_iss_mask[0] = 1'b0;
    end

    // Issue set takes priority over a writeback clear on the same register
    assign w_busy_nxt = (r_busy & ~w_wr_mask) | w_iss_mask;
    assign w_err_set  = |(w_wr_mask & ~r_busy);

    // Read port with optional forwarding of the current writeback
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS && wb_en) begin
            if (addr == wb_da) begin
                v = w_wb_lo;
            end else if (wb_pair && (addr == w_wb_da1)) begin
                v = w_wb_hi;
            end
        end
        if (addr == '0) begin
            v = '0;
        end
        return v;
    endfunction

    // Combinational operand reads
    always_comb begin
        a_data = f_read(iss_aa, r_regs[iss_aa]);
        b_data = f_read(iss_ba, r_regs[iss_ba]);
    end

    // Register storage; R0 stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (w_wr_mask[i]) begin
                    r_regs[i] <= (ADDR_W'(i) == wb_da) ? w_wb_lo : w_wb_hi;
                end
            end
        end
    end

    // Scoreboard, idle flag and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_idle <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_idle <= ~|w_busy_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign idle   = r_idle;
    assign wb_err = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass, one without, driven in
// lock-step and checked against a per-instance architectural model.
module tb_regfile_sb;

    localparam int N = 32;

    logic        clk;
    logic        rst;
    logic        iss_valid, iss_pair, iss_use_a, iss_use_b;
    logic [4:0]  iss_da, iss_aa, iss_ba;
    logic        wb_en, wb_pair;
    logic [4:0]  wb_da;
    logic [63:0] wb_data;

    logic        stall1, stall0, idle1, idle0, err1, err0;
    logic [31:0] a1, b1, a0, b0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut_bp (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_da(iss_da), .iss_pair(iss_pair),
        .iss_aa(iss_aa), .iss_ba(iss_ba), .iss_use_a(iss_use_a), .iss_use_b(iss_use_b),
        .stall(stall1), .a_data(a1), .b_data(b1),
        .wb_en(wb_en), .wb_da(wb_da), .wb_pair(wb_pair), .wb_data(wb_data),
        .idle(idle1), .wb_err(err1)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_da(iss_da), .iss_pair(iss_pair),
        .iss_aa(iss_aa), .iss_ba(iss_ba), .iss_use_a(iss_use_a), .iss_use_b(iss_use_b),
        .stall(stall0), .a_data(a0), .b_data(b0),
        .wb_en(wb_en), .wb_da(wb_da), .wb_pair(wb_pair), .wb_data(wb_data),
        .idle(idle0), .wb_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model; index 1 = bypass instance, 0 = no bypass
    logic [31:0] m_regs [2][N];
    bit          m_busy [2][N];
    bit          m_err  [2];
    bit          m_idle [2];

    typedef struct {
        logic        iv;  logic [4:0] da;  logic pr;
        logic [4:0]  aa;  logic [4:0] ba;  logic ua;  logic ub;
        logic        we;  logic [4:0] wd;  logic wp;  logic [63:0] wdat;
        logic        es1; logic es0;
        logic [31:0] ea1; logic [31:0] ea0; logic [31:0] eb1; logic [31:0] eb0;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bp(input int k);
        return k == 1;
    endfunction

    function automatic int inc(input logic [4:0] a);
        return (int'(a) + 1) % N;
    endfunction

    function automatic bit written(input int x);
        return wb_en && (x != 0) && ((x == int'(wb_da)) || (wb_pair && (x == inc(wb_da))));
    endfunction

    function automatic logic [31:0] m_read(input int k, input int x);
        if (x == 0) return 32'h0;
        if (bp(k) && written(x)) return (x == int'(wb_da)) ? wb_data[31:0] : wb_data[63:32];
        return m_regs[k][x];
    endfunction

    function automatic bit eff(input int k, input int x);
        return m_busy[k][x] && !(bp(k) && written(x));
    endfunction

    function automatic bit m_stall(input int k);
        return iss_valid && ((iss_use_a && eff(k, int'(iss_aa))) ||
                             (iss_use_b && eff(k, int'(iss_ba))) ||
                             eff(k, int'(iss_da)) ||
                             (iss_pair && eff(k, inc(iss_da))));
    endfunction

    function automatic logic [31:0] dut_a(input int k); return (k == 1) ? a1 : a0; endfunction
    function automatic logic [31:0] dut_b(input int k); return (k == 1) ? b1 : b0; endfunction
    function automatic logic dut_s(input int k); return (k == 1) ? stall1 : stall0; endfunction
    function automatic logic dut_i(input int k); return (k == 1) ? idle1 : idle0; endfunction
    function automatic logic dut_e(input int k); return (k == 1) ? err1 : err0; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < N; x++) begin
                m_regs[k][x] = 32'h0;
                m_busy[k][x] = 1'b0;
            end
            m_err[k]  = 1'b0;
            m_idle[k] = 1'b1;
        end
    endtask

    task automatic clear_in();
        iss_valid = 1'b0; iss_da = 5'd0; iss_pair = 1'b0;
        iss_aa = 5'd0; iss_ba = 5'd0; iss_use_a = 1'b0; iss_use_b = 1'b0;
        wb_en = 1'b0; wb_da = 5'd0; wb_pair = 1'b0; wb_data = 64'h0;
    endtask

    task automatic set_in(input vec_t v);
        iss_valid = v.iv; iss_da = v.da; iss_pair = v.pr;
        iss_aa = v.aa; iss_ba = v.ba; iss_use_a = v.ua; iss_use_b = v.ub;
        wb_en = v.we; wb_da = v.wd; wb_pair = v.wp; wb_data = v.wdat;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs
    task automatic tick();
        bit          st [2];
        logic [31:0] nr [2][N];
        bit          nb [2][N];
        bit          ne [2];
        bit          ni [2];
        int          d;
        #1;
        for (int k = 0; k < 2; k++) begin
            st[k] = m_stall(k);
            chk($sformatf("stall[bp=%0d]", k), 64'(dut_s(k)), 64'(st[k]));
            chk($sformatf("a_data[bp=%0d] aa=%0d", k, iss_aa), 64'(dut_a(k)), 64'(m_read(k, int'(iss_aa))));
            chk($sformatf("b_data[bp=%0d] ba=%0d", k, iss_ba), 64'(dut_b(k)), 64'(m_read(k, int'(iss_ba))));
            ne[k] = m_err[k];
            for (int x = 0; x < N; x++) begin
                nr[k][x] = m_regs[k][x];
                nb[k][x] = m_busy[k][x];
                if (written(x)) begin
                    nr[k][x] = (x == int'(wb_da)) ? wb_data[31:0] : wb_data[63:32];
                    if (!m_busy[k][x]) ne[k] = 1'b1;
                    nb[k][x] = 1'b0;
                end
            end
            if (iss_valid && !st[k]) begin
                d = int'(iss_da);
                if (d != 0) nb[k][d] = 1'b1;
                if (iss_pair && inc(iss_da) != 0) nb[k][inc(iss_da)] = 1'b1;
            end
            ni[k] = 1'b1;
            for (int x = 0; x < N; x++) if (nb[k][x]) ni[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < N; x++) begin
                m_regs[k][x] = nr[k][x];
                m_busy[k][x] = nb[k][x];
            end
            m_err[k]  = ne[k];
            m_idle[k] = ni[k];
            chk($sformatf("idle[bp=%0d]", k), 64'(dut_i(k)), 64'(m_idle[k]));
            chk($sformatf("wb_err[bp=%0d]", k), 64'(dut_e(k)), 64'(m_err[k]));
        end
    endtask

    // Reset pulse from a point just after a rising edge; returns at posedge+1
    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        #3;
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        tbl[0]  = '{1'b1, 5'd5,  1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 5'd6,  1'b0, 5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 5'd6,  1'b0, 5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 64'h0000_0000_0000_ABCD,
                    1'b0, 1'b1, 32'hABCD, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 5'd6,  1'b0, 5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b1, 1'b0, 32'hABCD, 32'hABCD, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0,  1'b0, 5'd6,  5'd5, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 64'h6,
                    1'b0, 1'b0, 32'h6, 32'h0, 32'hABCD, 32'hABCD};
        tbl[5]  = '{1'b1, 5'd7,  1'b1, 5'd6,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b0, 1'b0, 32'h6, 32'h6, 32'h0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0,  1'b0, 5'd8,  5'd7, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 64'h12345678_9ABCDEF0,
                    1'b0, 1'b0, 32'h12345678, 32'h0, 32'h9ABCDEF0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0,  1'b0, 5'd7,  5'd8, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b0, 1'b0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h12345678, 32'h12345678};
        tbl[8]  = '{1'b1, 5'd31, 1'b1, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0,  1'b0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 64'hFFFFFFFF_31313131,
                    1'b0, 1'b0, 32'h31313131, 32'h0, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 5'd0,  1'b0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 64'h0,
                    1'b0, 1'b0, 32'h31313131, 32'h31313131, 32'h0, 32'h0};

        // Power-up reset
        clear_in();
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // All addresses read zero after reset
        for (int x = 0; x < N; x++) begin
            iss_aa = 5'(x);
            iss_ba = 5'(N - 1 - x);
            iss_use_a = 1'b1;
            #1;
            chk($sformatf("rst_a1[%0d]", x), 64'(a1), 64'h0);
            chk($sformatf("rst_b0[%0d]", x), 64'(b0), 64'h0);
            if (x % 8 == 0) begin
                chk("rst_a0", 64'(a0), 64'h0);
                chk("rst_b1", 64'(b1), 64'h0);
                chk("rst_stall1", 64'(stall1), 64'h0);
                chk("rst_stall0", 64'(stall0), 64'h0);
            end
        end
        chk("rst_idle1", 64'(idle1), 64'h1);
        chk("rst_idle0", 64'(idle0), 64'h1);
        chk("rst_err1", 64'(err1), 64'h0);
        chk("rst_err0", 64'(err0), 64'h0);
        @(posedge clk);
        #1;
        clear_in();

        // RAW hazard, pair writeback and wrap-around vectors
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i]);
            #1;
            chk($sformatf("vec%0d_stall_bp", i), 64'(stall1), 64'(tbl[i].es1));
            chk($sformatf("vec%0d_stall_nb", i), 64'(stall0), 64'(tbl[i].es0));
            chk($sformatf("vec%0d_a_bp", i), 64'(a1), 64'(tbl[i].ea1));
            chk($sformatf("vec%0d_a_nb", i), 64'(a0), 64'(tbl[i].ea0));
            chk($sformatf("vec%0d_b_bp", i), 64'(b1), 64'(tbl[i].eb1));
            chk($sformatf("vec%0d_b_nb", i), 64'(b0), 64'(tbl[i].eb0));
            tick();
        end
        chk("wrap_idle_bp", 64'(idle1), 64'h1);
        chk("wrap_idle_nb", 64'(idle0), 64'h1);
        chk("wrap_err_bp", 64'(err1), 64'h0);
        chk("wrap_err_nb", 64'(err0), 64'h0);

        // Same-cycle issue and writeback on R3
        clear_in(); iss_valid = 1'b1; iss_da = 5'd3;
        tick();
        wb_en = 1'b1; wb_da = 5'd3; wb_data = 64'h33;
        #1;
        chk("r3_stall_bp", 64'(stall1), 64'h0);
        chk("r3_stall_nb", 64'(stall0), 64'h1);
        tick();
        chk("r3_idle_bp", 64'(idle1), 64'h0);
        chk("r3_idle_nb", 64'(idle0), 64'h1);
        clear_in(); iss_aa = 5'd3;
        #1;
        chk("r3_val_bp", 64'(a1), 64'h33);
        chk("r3_val_nb", 64'(a0), 64'h33);
        tick();
        clear_in(); wb_en = 1'b1; wb_da = 5'd3; wb_data = 64'h44;
        tick();
        chk("r3_clear_err_bp", 64'(err1), 64'h0);
        chk("r3_clear_err_nb", 64'(err0), 64'h1);
        chk("r3_clear_idle_bp", 64'(idle1), 64'h1);

        // Writeback to a never-issued register sets a sticky error
        clear_in(); wb_en = 1'b1; wb_da = 5'd9; wb_data = 64'h99;
        tick();
        chk("r9_err_bp", 64'(err1), 64'h1);
        clear_in();
        for (int i = 0; i < 5; i++) tick();
        chk("err_sticky_bp", 64'(err1), 64'h1);
        chk("err_sticky_nb", 64'(err0), 64'h1);

        // Asynchronous reset with a claim outstanding
        clear_in(); iss_valid = 1'b1; iss_da = 5'd10;
        tick();
        clear_in(); iss_aa = 5'd9;
        #1;
        chk("pre_arst_a", 64'(a1), 64'h99);
        chk("pre_arst_idle", 64'(idle1), 64'h0);
        rst = 1'b1;
        #1;
        chk("arst_a_bp", 64'(a1), 64'h0);
        chk("arst_a_nb", 64'(a0), 64'h0);
        chk("arst_idle_bp", 64'(idle1), 64'h1);
        chk("arst_err_bp", 64'(err1), 64'h0);
        chk("arst_err_nb", 64'(err0), 64'h0);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_in(); wb_en = 1'b1; wb_da = 5'd10; wb_data = 64'h10;
        tick();
        chk("stale_wb_err_bp", 64'(err1), 64'h1);
        chk("stale_wb_err_nb", 64'(err0), 64'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 0) do_reset();
            iss_valid = 1'($urandom_range(0, 1));
            iss_da    = 5'($urandom_range(0, N - 1));
            iss_pair  = ($urandom_range(0, 3) == 0);
            iss_aa    = 5'($urandom_range(0, N - 1));
            iss_ba    = 5'($urandom_range(0, N - 1));
            iss_use_a = 1'($urandom_range(0, 1));
            iss_use_b = 1'($urandom_range(0, 1));
            wb_pair   = ($urandom_range(0, 3) == 0);
            wb_data   = {$urandom, $urandom};
            q.delete();
            for (int x = 0; x < N; x++) if (m_busy[1][x]) q.push_back(x);
            wb_en = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 19) != 0)
                wb_da = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_da = 5'($urandom_range(0, N - 1));
            if (wb_pair && m_busy[1][inc(wb_da)] == 1'b0 && $urandom_range(0, 3) != 0)
                wb_pair = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
